// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file write-port arbiter.
//   DW_DEF / AW_DEF : default data / register-address widths
//   arb_state_t     : arbiter mode (IDLE: nothing buffered, DRAIN: buffered
//                     results written on WB bubbles, FORCE: bubbles requested)
//   arb_entry_t     : one buffered long-latency result
package wb_arb_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

  // The entry width is fixed by the package defaults; the top-level DW/AW
  // parameters must match them.
  typedef struct packed {
    logic              valid;
    logic              kill;
    logic [AW_DEF-1:0] destR;
    logic [DW_DEF-1:0] data;
  } arb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Circular buffer of long-latency results waiting for the register-file port.
//   clk, rst        : clock, async active-low reset (discards all entries)
//   push/push_entry : store an entry (ignored when full)
//   pop             : retire the head (ignored when empty)
//   kill_en/addr    : mark every stored entry with destR == kill_addr as killed
//   head            : current head entry (valid=0 when empty)
//   full/empty      : occupancy flags
//   count           : registered live-entry count (wr - rd with extra MSB)
module wb_result_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  arb_entry_t        push_entry,
  input  logic              pop,
  input  logic              kill_en,
  input  logic [AW_DEF-1:0] kill_addr,
  output arb_entry_t        head,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  arb_entry_t       mem [DEPTH];
  logic [CW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [DEPTH-1:0] kill_hit;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_nxt  = wr_ptr + CW'(do_push);
  assign rd_nxt  = rd_ptr + CW'(do_pop);
  assign head    = mem[rd_ptr[PW-1:0]];

  // Every slot compares its destination against the WB address in parallel.
  for (genvar i = 0; i < DEPTH; i++) begin : g_kill
    assign kill_hit[i] = kill_en && mem[i].valid && (mem[i].destR == kill_addr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill_hit[i]) mem[i].kill <= 1'b1;
      if (do_pop)  mem[rd_ptr[PW-1:0]].valid <= 1'b0;
      // The write slot is never a live slot (push is blocked when full),
      // so it cannot collide with the kill or pop updates above.
      if (do_push) mem[wr_ptr[PW-1:0]] <= push_entry;
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      count  <= wr_nxt - rd_nxt;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage (always wins,
// never stalls) and a long-latency unit whose results queue in a FIFO and are
// written on WB bubbles. stall_req forces bubbles when the head has starved
// for STARVE_MAX cycles or the FIFO is full.
//   clk, rst                   : clock, async active-low reset
//   wb_wreg/wb_destR/wb_dest   : WB stage write (r0 writes ignored)
//   lu_valid/lu_destR/lu_data  : long-latency result, accepted when lu_ready
//   lu_ready                   : FIFO not full (combinational)
//   rf_we/rf_waddr/rf_wdata    : registered register-file write port
//   stall_req                  : registered bubble request
//   fifo_cnt                   : registered FIFO occupancy
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int DW         = DW_DEF,
  parameter int AW         = AW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_wreg,
  input  logic [AW-1:0]          wb_destR,
  input  logic [DW-1:0]          wb_dest,
  input  logic                   lu_valid,
  input  logic [AW-1:0]          lu_destR,
  input  logic [DW-1:0]          lu_data,
  output logic                   lu_ready,
  output logic                   rf_we,
  output logic [AW-1:0]          rf_waddr,
  output logic [DW-1:0]          rf_wdata,
  output logic                   stall_req,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  arb_state_t    state;
  arb_entry_t    head, push_entry;
  logic          full, empty;
  logic          wb_req, head_valid, head_live, head_dead;
  logic          grant_lu, pop, store;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [CW-1:0] cnt_nxt;

  assign wb_req     = wb_wreg && (wb_destR != '0);
  assign head_valid = !empty && head.valid;
  assign head_live  = head_valid && !head.kill;
  assign head_dead  = head_valid && head.kill;
  assign grant_lu   = !wb_req && head_live;
  // A killed head needs no port slot, so it retires even under WB traffic.
  assign pop        = grant_lu || head_dead;
  assign lu_ready   = !full;
  // r0 results and results already superseded by this cycle's WB write
  // complete the handshake but are not stored.
  assign store      = lu_valid && lu_ready && (lu_destR != '0) &&
                      !(wb_req && (lu_destR == wb_destR));
  assign push_entry = '{valid: 1'b1, kill: 1'b0, destR: lu_destR, data: lu_data};
  assign cnt_nxt    = fifo_cnt + CW'(store) - CW'(pop);
  // Only a live head that lost to WB starves; pop or empty clears.
  assign starve_nxt = !(head_live && wb_req) ? '0 :
                      (starve_cnt == SMAX)   ? SMAX : starve_cnt + SW'(1);

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (store),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (wb_req),
    .kill_addr  (wb_destR),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (fifo_cnt)
  );

  // Transitions look at next-cycle occupancy/starvation so that a pop in
  // the same cycle is taken into account. stall_req follows the state one
  // cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      stall_req  <= 1'b0;
      starve_cnt <= '0;
    end else begin
      stall_req  <= (state == FORCE);
      starve_cnt <= starve_nxt;
      case (state)
        IDLE:  if (cnt_nxt != '0) state <= DRAIN;
        DRAIN: begin
          if (starve_nxt == SMAX || cnt_nxt == CW'(DEPTH)) state <= FORCE;
          else if (cnt_nxt == '0)                          state <= IDLE;
        end
        FORCE: begin
          if (cnt_nxt == '0) state <= IDLE;
          else if (pop && cnt_nxt < CW'(DEPTH) && starve_nxt == '0)
            state <= DRAIN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (wb_req) begin
      rf_we    <= 1'b1;
      rf_waddr <= wb_destR;
      rf_wdata <= wb_dest;
    end else if (grant_lu) begin
      rf_we    <= 1'b1;
      rf_waddr <= head.destR;
      rf_wdata <= head.data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_wreg, lu_valid;
  logic [4:0]  wb_destR, lu_destR;
  logic [31:0] wb_dest, lu_data;
  logic        lu_ready, rf_we, stall_req;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  fifo_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .DW(32), .AW(5), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .wb_wreg(wb_wreg), .wb_destR(wb_destR), .wb_dest(wb_dest),
    .lu_valid(lu_valid), .lu_destR(lu_destR), .lu_data(lu_data),
    .lu_ready(lu_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .fifo_cnt(fifo_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic st, input logic [1:0] cnt);
    chk({tag, "_we"},    32'(rf_we),     32'(we));
    chk({tag, "_waddr"}, 32'(rf_waddr),  32'(wa));
    chk({tag, "_wdata"}, rf_wdata,       wd);
    chk({tag, "_stall"}, 32'(stall_req), 32'(st));
    chk({tag, "_cnt"},   32'(fifo_cnt),  32'(cnt));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic wbw; logic [4:0] wbd; logic [31:0] wbv;
    logic luv; logic [4:0] lud; logic [31:0] ludv;
    logic rdy;
    logic we;  logic [4:0] wa;  logic [31:0] wd;
    logic st;  logic [1:0] cnt;
  } vec_t;

  vec_t tbl [26];

  function automatic vec_t mk(logic wbw, logic [4:0] wbd, logic [31:0] wbv,
                              logic luv, logic [4:0] lud, logic [31:0] ludv,
                              logic rdy, logic we, logic [4:0] wa, logic [31:0] wd,
                              logic st, logic [1:0] cnt);
    vec_t v;
    v = '{wbw, wbd, wbv, luv, lud, ludv, rdy, we, wa, wd, st, cnt};
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct { logic [4:0] d; logic [31:0] v; bit k; } ment_t;
  ment_t       m_q[$];
  int          m_starve;
  bit          m_force, m_stall, m_fire, m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  task automatic model_reset();
    m_q.delete();
    m_starve = 0; m_force = 0; m_stall = 0; m_fire = 0;
    m_we = 0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_step();
    bit wbreq, ready, popped, starving;
    ment_t e;
    wbreq  = wb_wreg && (wb_destR != 5'd0);
    ready  = m_q.size() < DEPTH;
    popped = 0;
    if (wbreq) begin
      m_we = 1; m_addr = wb_destR; m_data = wb_dest;
    end else if (m_q.size() > 0 && !m_q[0].k) begin
      m_we = 1; m_addr = m_q[0].d; m_data = m_q[0].v;
      void'(m_q.pop_front()); popped = 1;
    end else begin
      m_we = 0;
    end
    if (!popped && m_q.size() > 0 && m_q[0].k) begin
      void'(m_q.pop_front()); popped = 1;
    end
    starving = !popped && m_q.size() > 0 && !m_q[0].k && wbreq;
    m_starve = starving ? ((m_starve + 1 > SMAX) ? SMAX : m_starve + 1) : 0;
    if (wbreq) foreach (m_q[i]) if (m_q[i].d == wb_destR) m_q[i].k = 1;
    m_fire = lu_valid && ready;
    if (m_fire && lu_destR != 5'd0 && !(wbreq && lu_destR == wb_destR)) begin
      e.d = lu_destR; e.v = lu_data; e.k = 0;
      m_q.push_back(e);
    end
    m_stall = m_force;
    if (!m_force) m_force = (m_starve == SMAX) || (m_q.size() == DEPTH);
    else if (m_q.size() == 0 || (popped && m_q.size() < DEPTH && m_starve == 0))
      m_force = 0;
  endtask

  task automatic idle_inputs();
    wb_wreg = 0; wb_destR = '0; wb_dest = '0;
    lu_valid = 0; lu_destR = '0; lu_data = '0;
  endtask

  initial begin
    int thresh;
    bit seen;
    //           wbw  wbd    wbv          luv  lud    ludv          rdy  we   wa     wd           st   cnt
    tbl[0]  = mk(1'b1,5'd3, 32'h11,       1'b0,5'd0, 32'h0,        1'b1,1'b1,5'd3, 32'h11,      1'b0,2'd0);
    tbl[1]  = mk(1'b1,5'd3, 32'h11,       1'b0,5'd0, 32'h0,        1'b1,1'b1,5'd3, 32'h11,      1'b0,2'd0);
    tbl[2]  = mk(1'b0,5'd0, 32'h0,        1'b1,5'd7, 32'hABCD,     1'b1,1'b0,5'd3, 32'h11,      1'b0,2'd1);
    tbl[3]  = mk(1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b1,5'd7, 32'hABCD,    1'b0,2'd0);
    tbl[4]  = mk(1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,5'd7, 32'hABCD,    1'b0,2'd0);
    tbl[5]  = mk(1'b1,5'd4, 32'h22,       1'b1,5'd9, 32'h99,       1'b1,1'b1,5'd4, 32'h22,      1'b0,2'd1);
    tbl[6]  = mk(1'b1,5'd4, 32'h22,       1'b0,5'd0, 32'h0,        1'b1,1'b1,5'd4, 32'h22,      1'b0,2'd1);
    tbl[7]  = mk(1'b1,5'd4, 32'h22,       1'b0,5'd0, 32'h0,        1'b1,1'b1,5'd4, 32'h22,      1'b0,2'd1);
    tbl[8]  = mk(1'b1,5'd4, 32'h22,       1'b0,5'd0, 32'h0,        1'b1,1'b1,5'd4, 32'h22,      1'b0,2'd1);
    tbl[9]  = mk(1'b1,5'd4, 32'h22,       1'b0,5'd0, 32'h0,        1'b1,1'b1,5'd4, 32'h22,      1'b0,2'd1);
    tbl[10] = mk(1'b1,5'd4, 32'h22,       1'b0,5'd0, 32'h0,        1'b1,1'b1,5'd4, 32'h22,      1'b1,2'd1);
    tbl[11] = mk(1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b1,5'd9, 32'h99,      1'b1,2'd0);
    tbl[12] = mk(1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,5'd9, 32'h99,      1'b0,2'd0);
    tbl[13] = mk(1'b1,5'd3, 32'h33,       1'b1,5'd10,32'hA0,       1'b1,1'b1,5'd3, 32'h33,      1'b0,2'd1);
    tbl[14] = mk(1'b1,5'd3, 32'h33,       1'b1,5'd11,32'hB0,       1'b1,1'b1,5'd3, 32'h33,      1'b0,2'd2);
    tbl[15] = mk(1'b1,5'd3, 32'h33,       1'b1,5'd12,32'hC0,       1'b0,1'b1,5'd3, 32'h33,      1'b1,2'd2);
    tbl[16] = mk(1'b0,5'd0, 32'h0,        1'b1,5'd12,32'hC0,       1'b0,1'b1,5'd10,32'hA0,      1'b1,2'd1);
    tbl[17] = mk(1'b0,5'd0, 32'h0,        1'b1,5'd12,32'hC0,       1'b1,1'b1,5'd11,32'hB0,      1'b0,2'd1);
    tbl[18] = mk(1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b1,5'd12,32'hC0,      1'b0,2'd0);
    tbl[19] = mk(1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,5'd12,32'hC0,      1'b0,2'd0);
    tbl[20] = mk(1'b0,5'd0, 32'h0,        1'b1,5'd5, 32'h1,        1'b1,1'b0,5'd12,32'hC0,      1'b0,2'd1);
    tbl[21] = mk(1'b1,5'd5, 32'h2,        1'b1,5'd5, 32'h3,        1'b1,1'b1,5'd5, 32'h2,       1'b0,2'd1);
    tbl[22] = mk(1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,5'd5, 32'h2,       1'b0,2'd0);
    tbl[23] = mk(1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,5'd5, 32'h2,       1'b0,2'd0);
    tbl[24] = mk(1'b1,5'd0, 32'hDEAD,     1'b1,5'd0, 32'hBEEF,     1'b1,1'b0,5'd5, 32'h2,       1'b0,2'd0);
    tbl[25] = mk(1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,1'b0,5'd5, 32'h2,       1'b0,2'd0);

    // reset state
    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk_outs("reset", 1'b0, 5'd0, 32'h0, 1'b0, 2'd0);
    chk("reset_ready", 32'(lu_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // directed table
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      wb_wreg = tbl[i].wbw; wb_destR = tbl[i].wbd; wb_dest = tbl[i].wbv;
      lu_valid = tbl[i].luv; lu_destR = tbl[i].lud; lu_data = tbl[i].ludv;
      #1 chk($sformatf("row%0d_ready", i), 32'(lu_ready), 32'(tbl[i].rdy));
      @(posedge clk);
      #1 chk_outs($sformatf("row%0d", i), tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].st, tbl[i].cnt);
    end

    // reset in the middle of a forced drain
    @(negedge clk);
    wb_wreg = 1; wb_destR = 5'd3; wb_dest = 32'h44;
    lu_valid = 1; lu_destR = 5'd20; lu_data = 32'h200;
    @(negedge clk);
    lu_destR = 5'd21; lu_data = 32'h210;
    @(negedge clk);
    lu_valid = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk);
      #1 seen = stall_req;
    end
    chk("middrain_stall_reached", 32'(seen), 32'd1);
    chk("middrain_cnt", 32'(fifo_cnt), 32'd2);
    #1;
    rst = 1'b0;
    idle_inputs();
    #1;
    chk_outs("async_reset", 1'b0, 5'd0, 32'h0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1 chk_outs($sformatf("post_reset%0d", c), 1'b0, 5'd0, 32'h0, 1'b0, 2'd0);
    end

    // randomized traffic against the reference model
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      thresh = 3 + 3 * ((i / 250) % 3);
      if (!(lu_valid && !m_fire)) begin
        lu_valid = ($urandom_range(0, 1) == 1);
        lu_destR = 5'($urandom_range(0, 7));
        lu_data  = $urandom;
      end
      wb_wreg  = ($urandom_range(0, 9) < thresh);
      wb_destR = 5'($urandom_range(0, 7));
      wb_dest  = $urandom;
      #1 chk("rand_ready", 32'(lu_ready), 32'(m_q.size() < DEPTH));
      @(posedge clk);
      model_step();
      #1 chk_outs("rand", m_we, m_addr, m_data, m_stall, 2'(m_q.size()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
